register_bank_plus: RTL

//  Parametrised successor to the single 8-bit save/load register: NUM_REGS registers of

---
 rtl/register_bank_plus_pkg.sv | 20 ++
 rtl/register_bank_plus_read_port.sv | 65 ++++++
 rtl/register_bank_plus.sv | 100 ++++++++++
 3 files changed

// File: rtl/register_bank_plus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared defaults and helpers for register_bank_plus and its read ports.
//   DEF_DATA_W     default register width
//   DEF_NUM_REGS   default register count
//   DEF_COUNT_STEP default increment applied to register 0
//   addr_valid()   true when an address selects an implemented register
// -----------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_REGS   = 8;
  localparam int DEF_COUNT_STEP = 4;

  // Registers need not be a power of two, so the top of the address space may be empty.
  function automatic logic addr_valid(input logic [31:0] addr, input logic [31:0] num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/register_bank_plus_read_port.sv
// -----------------------------------------------------------------------------
// reg_bank_read_port
// One combinational read port of register_bank_plus.
// Build option: REG_BANK_BYPASS_EN forwards an in-flight write to this port.
// Ports:
//   i_load        read enable (disabled port drives 0)
//   i_addr        read address (unimplemented address reads 0)
//   i_bank        flat copy of every register, reg i at [i*DATA_W +: DATA_W]
//   i_save        write strobe of the bank (used only for forwarding)
//   i_save_addr   write address of the bank (used only for forwarding)
//   i_save_value  write data of the bank (used only for forwarding)
//   o_data        read data
// -----------------------------------------------------------------------------
module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       i_load,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [NUM_REGS*DATA_W-1:0] i_bank,
  input  logic                       i_save,
  input  logic [ADDR_W-1:0]          i_save_addr,
  input  logic [DATA_W-1:0]          i_save_value,
  output logic [DATA_W-1:0]          o_data
);

  logic [DATA_W-1:0] w_stored;
  logic              w_fwd;

  // Select the addressed register; the loop leaves unimplemented addresses at zero.
  always_comb begin
    w_stored = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_addr == ADDR_W'(i)) begin
        w_stored = i_bank[i*DATA_W +: DATA_W];
      end else begin
        w_stored = w_stored;
      end
    end
  end

`ifdef REG_BANK_BYPASS_EN
  // A dropped (out-of-range) write must never be forwarded.
  assign w_fwd = i_save && addr_valid(32'(i_save_addr), 32'(NUM_REGS)) && (i_addr == i_save_addr);
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_save, i_save_addr, i_save_value};
  assign w_fwd = 1'b0;
`endif

  // Enable gate and optional forwarding mux.
  always_comb begin
    if (!i_load) begin
      o_data = {DATA_W{1'b0}};
    end else if (w_fwd) begin
      o_data = i_save_value;
    end else begin
      o_data = w_stored;
    end
  end

endmodule

// File: rtl/register_bank_plus.sv
// -----------------------------------------------------------------------------
// register_bank_plus
// NUM_REGS x DATA_W register bank with one write port, two read ports, a flat
// always-visible copy of the bank and a COUNT_STEP counter on register 0.
// Build option: REG_BANK_BYPASS_EN enables write-to-read forwarding on both ports.
// Ports:
//   clk, rst                   rising-edge clock, async active-high reset
//   save/save_addr/save_value  write port (out-of-range address drops the write)
//   load_a/addr_a/out_a        read port A, combinational
//   load_b/addr_b/out_b        read port B, combinational
//   count_en                   advance register 0 by COUNT_STEP (a write to reg 0 wins)
//   count_out                  registered value of register 0
//   always_output              all registers, reg i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module register_bank_plus
  import reg_bank_pkg::*;
#(
  parameter int  UUID       = 0,
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  NUM_REGS   = DEF_NUM_REGS,
  parameter int  COUNT_STEP = DEF_COUNT_STEP,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       save,
  input  logic [ADDR_W-1:0]          save_addr,
  input  logic [DATA_W-1:0]          save_value,
  input  logic                       load_a,
  input  logic [ADDR_W-1:0]          addr_a,
  output logic [DATA_W-1:0]          out_a,
  input  logic                       load_b,
  input  logic [ADDR_W-1:0]          addr_b,
  output logic [DATA_W-1:0]          out_b,
  input  logic                       count_en,
  output logic [DATA_W-1:0]          count_out,
  output logic [NUM_REGS*DATA_W-1:0] always_output
);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] w_bank;
  logic                       w_save_ok;

  assign w_save_ok = save && addr_valid(32'(save_addr), 32'(NUM_REGS));

  // Storage and program counter; the write is applied after the increment so a
  // jump to register 0 overrides the count on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (count_en) begin
        r_regs[0] <= r_regs[0] + DATA_W'(COUNT_STEP);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_save_ok && (save_addr == ADDR_W'(i))) begin
          r_regs[i] <= save_value;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_bank[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign always_output = w_bank;
  assign count_out     = r_regs[0];

  reg_bank_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port_a (
    .i_load       (load_a),
    .i_addr       (addr_a),
    .i_bank       (w_bank),
    .i_save       (save),
    .i_save_addr  (save_addr),
    .i_save_value (save_value),
    .o_data       (out_a)
  );

  reg_bank_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port_b (
    .i_load       (load_b),
    .i_addr       (addr_b),
    .i_bank       (w_bank),
    .i_save       (save),
    .i_save_addr  (save_addr),
    .i_save_value (save_value),
    .o_data       (out_b)
  );

endmodule
